// File: rtl/silife_bridge_pkg.sv
// Shared constants and state encodings for the silife UART-to-Wishbone bridge.
package silife_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WB,
    ST_RESP
  } cmd_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

endpackage

// File: rtl/silife_uart.sv
// 8N1 UART: synchronised receiver with glitch reject and framing check, plus a
// single-byte transmitter. Valid/frame-error outputs are one-cycle pulses.
module silife_uart
  import silife_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_frame_err,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

  rx_state_t       r_rx_state, w_rx_state_nxt;
  tx_state_t       r_tx_state, w_tx_state_nxt;
  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  logic [CW-1:0]   r_rx_clk, r_tx_clk;
  logic [2:0]      r_rx_bit;
  logic [3:0]      r_tx_bit;
  logic [7:0]      r_rx_shift;
  logic [8:0]      r_tx_shift;
  logic            r_rx_valid, r_rx_ferr, r_tx;
  logic            w_rx_tick, w_rx_mid, w_tx_tick;

  assign w_rx_tick      = (r_rx_clk == BIT_LAST);
  assign w_rx_mid       = (r_rx_clk == BIT_HALF);
  assign w_tx_tick      = (r_tx_clk == BIT_LAST);
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_data      = r_rx_shift;
  assign o_rx_frame_err = r_rx_ferr;
  assign o_tx           = r_tx;
  assign o_tx_busy      = (r_tx_state != TX_IDLE);

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_tx_state_nxt = r_tx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_mid) w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_state_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_state_nxt = RX_IDLE;
      default:  w_rx_state_nxt = RX_IDLE;
    endcase
    case (r_tx_state)
      TX_IDLE:  if (i_tx_start) w_tx_state_nxt = TX_SHIFT;
      TX_SHIFT: if (w_tx_tick && (r_tx_bit == 4'd9)) w_tx_state_nxt = TX_IDLE;
      default:  w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // Receive: the bit counter restarts on every state change so the start-bit
  // re-check lands mid-bit and every later sample stays mid-bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_clk   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_meta  <= i_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_clk   <= ((w_rx_state_nxt != r_rx_state) || w_rx_tick) ? '0 : r_rx_clk + CW'(1);
      if (r_rx_state == RX_START) r_rx_bit <= '0;
      if ((r_rx_state == RX_DATA) && w_rx_tick) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
      r_rx_valid <= (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;
      r_rx_ferr  <= (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync;
    end
  end

  // Transmit: shift register holds data plus stop bit; ones fill in behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_shift <= '1;
      r_tx_clk   <= '0;
      r_tx_bit   <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (r_tx_state == TX_IDLE) begin
        if (i_tx_start) begin
          r_tx       <= 1'b0;
          r_tx_shift <= {1'b1, i_tx_data};
          r_tx_clk   <= '0;
          r_tx_bit   <= '0;
        end
      end else if (w_tx_tick) begin
        r_tx       <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_clk   <= '0;
        r_tx_bit   <= r_tx_bit + 4'd1;
      end else begin
        r_tx_clk   <= r_tx_clk + CW'(1);
      end
    end
  end

endmodule

// File: rtl/silife_uart_wb_bridge.sv
// Host-UART command decoder driving single classic Wishbone cycles.
// Optional SILIFE_BRIDGE_TIMEOUT_EN aborts an unacknowledged cycle after WB_TIMEOUT clocks.
module silife_uart_wb_bridge
  import silife_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
`ifdef SILIFE_BRIDGE_TIMEOUT_EN
  , parameter int WB_TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic        o_busy
);

  cmd_state_t  r_state, w_state_nxt;
  logic [2:0]  r_cnt, r_len;
  logic        r_we, r_nak, r_wb_cyc, r_wb_we;
  logic [31:0] r_addr_sh, r_data_sh, r_wb_addr, r_wb_data, r_rdata;
  logic        w_rx_valid, w_rx_ferr, w_tx_start, w_tx_busy, w_timeout, w_known;
  logic [7:0]  w_rx_data, w_tx_data;

  silife_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .i_clk          (clk),
    .i_rst_n        (reset),
    .i_rx           (uart_rx),
    .o_tx           (uart_tx),
    .o_rx_valid     (w_rx_valid),
    .o_rx_data      (w_rx_data),
    .o_rx_frame_err (w_rx_ferr),
    .i_tx_start     (w_tx_start),
    .i_tx_data      (w_tx_data),
    .o_tx_busy      (w_tx_busy)
  );

  assign o_wb_cyc  = r_wb_cyc;
  assign o_wb_stb  = r_wb_cyc;
  assign o_wb_we   = r_wb_we;
  assign o_wb_addr = r_wb_addr;
  assign o_wb_data = r_wb_data;
  assign o_busy    = (r_state != ST_IDLE);
  assign w_known   = (w_rx_data == CMD_WRITE) || (w_rx_data == CMD_READ);

`ifdef SILIFE_BRIDGE_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_to_cnt <= '0;
    else if (!r_wb_cyc) r_to_cnt <= '0;
    else                r_to_cnt <= r_to_cnt + 16'd1;
  end
  assign w_timeout = r_wb_cyc && (r_to_cnt == 16'(WB_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tx_start  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_rx_valid) w_state_nxt = w_known ? ST_ADDR : ST_RESP;
      ST_ADDR: begin
        if (w_rx_ferr) w_state_nxt = ST_IDLE;
        else if (w_rx_valid && (r_cnt == 3'd3)) w_state_nxt = r_we ? ST_DATA : ST_WB;
      end
      ST_DATA: begin
        if (w_rx_ferr) w_state_nxt = ST_IDLE;
        else if (w_rx_valid && (r_cnt == 3'd3)) w_state_nxt = ST_WB;
      end
      ST_WB:   if (i_wb_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: begin
        // Stay here until the final byte has fully left the transmitter.
        if (!w_tx_busy) begin
          if (r_cnt == r_len) w_state_nxt = ST_IDLE;
          else                w_tx_start  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_data = RSP_ACK;
    if (r_nak) w_tx_data = RSP_NAK;
    else if (!r_we) begin
      case (r_cnt[1:0])
        2'd0:    w_tx_data = r_rdata[31:24];
        2'd1:    w_tx_data = r_rdata[23:16];
        2'd2:    w_tx_data = r_rdata[15:8];
        default: w_tx_data = r_rdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_we      <= 1'b0;
      r_nak     <= 1'b0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_wb_cyc  <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (w_rx_valid) begin
          r_cnt <= '0;
          r_len <= 3'd1;
          r_we  <= (w_rx_data == CMD_WRITE);
          r_nak <= !w_known;
        end
        ST_ADDR: if (w_rx_valid) begin
          r_addr_sh <= {r_addr_sh[23:0], w_rx_data};
          r_cnt     <= (r_cnt == 3'd3) ? 3'd0 : r_cnt + 3'd1;
          if ((r_cnt == 3'd3) && !r_we) begin
            r_wb_cyc  <= 1'b1;
            r_wb_we   <= 1'b0;
            r_wb_addr <= {r_addr_sh[23:0], w_rx_data};
          end
        end
        ST_DATA: if (w_rx_valid) begin
          r_data_sh <= {r_data_sh[23:0], w_rx_data};
          r_cnt     <= (r_cnt == 3'd3) ? 3'd0 : r_cnt + 3'd1;
          if (r_cnt == 3'd3) begin
            r_wb_cyc  <= 1'b1;
            r_wb_we   <= 1'b1;
            r_wb_addr <= r_addr_sh;
            r_wb_data <= {r_data_sh[23:0], w_rx_data};
          end
        end
        ST_WB: if (i_wb_ack || w_timeout) begin
          r_wb_cyc <= 1'b0;
          r_wb_we  <= 1'b0;
          r_cnt    <= '0;
          // An ack arriving together with the timeout takes priority.
          if (i_wb_ack) begin
            r_rdata <= i_wb_data;
            r_len   <= r_we ? 3'd1 : 3'd4;
          end else begin
            r_nak   <= 1'b1;
            r_len   <= 3'd1;
          end
        end
        ST_RESP: if (w_tx_start) r_cnt <= r_cnt + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_silife_uart_wb_bridge.sv
// Directed bench for silife_uart_wb_bridge: UART host model, Wishbone slave model, byte monitor.
module tb_silife_uart_wb_bridge;

  localparam int CLKS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, o_busy;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack = 1'b0;
  logic [31:0] i_wb_data = 32'h0;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rxq[$];
  int          n_cycles = 0, late_drop = 0, early_drop = 0, cyc_cnt = 0;
  logic        slave_en = 1'b1;
  int          slave_delay = 0;
  logic [31:0] slave_rdata = 32'h0;
  logic [31:0] cap_addr = 32'h0, cap_data = 32'h0;
  logic        cap_we = 1'b0;

  always #5 clk = ~clk;

  silife_uart_wb_bridge #(.CLKS_PER_BIT(CLKS)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .o_wb_cyc  (o_wb_cyc),
    .o_wb_stb  (o_wb_stb),
    .o_wb_we   (o_wb_we),
    .o_wb_addr (o_wb_addr),
    .o_wb_data (o_wb_data),
    .i_wb_ack  (i_wb_ack),
    .i_wb_data (i_wb_data),
    .o_busy    (o_busy)
  );

  // Wishbone slave: acks slave_delay cycles after the cycle opens, records the request.
  initial begin
    forever begin
      @(negedge clk);
      if (i_wb_ack) begin
        if (o_wb_cyc) late_drop++;
        i_wb_ack = 1'b0;
        cyc_cnt  = 0;
      end else if (o_wb_cyc && o_wb_stb) begin
        if (cyc_cnt == 0) begin
          cap_addr = o_wb_addr;
          cap_data = o_wb_data;
          cap_we   = o_wb_we;
          n_cycles++;
        end
        cyc_cnt++;
        if (slave_en && (cyc_cnt > slave_delay)) begin
          i_wb_ack  = 1'b1;
          i_wb_data = slave_rdata;
        end
      end else begin
        if ((cyc_cnt != 0) && slave_en) early_drop++;
        cyc_cnt = 0;
      end
    end
  end

  // UART monitor on uart_tx: decodes 8N1 bytes into rxq.
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    b    = 8'h00;
    forever begin
      @(negedge clk);
      if (prev && !uart_tx) begin
        repeat (CLKS / 2) @(negedge clk);
        if (!uart_tx) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CLKS) @(negedge clk);
            b[i] = uart_tx;
          end
          repeat (CLKS) @(negedge clk);
          if (uart_tx) rxq.push_back(b);
        end
      end
      prev = uart_tx;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] popq();
    if (rxq.size() > 0) return rxq.pop_front();
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CLKS) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_q(input int n, input string tag);
    int t = 0;
    while ((rxq.size() < n) && (t < 400 * CLKS)) begin
      @(negedge clk);
      t++;
    end
    chk(tag, rxq.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (o_busy && (t < 400 * CLKS)) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(o_busy), 32'h0);
  endtask

  task automatic wait_cyc(input string tag);
    int t = 0;
    while (!o_wb_cyc && (t < 100 * CLKS)) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(o_wb_cyc), 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " uart_tx"}, 32'(uart_tx), 32'h1);
    chk({tag, " cyc"},     32'(o_wb_cyc), 32'h0);
    chk({tag, " stb"},     32'(o_wb_stb), 32'h0);
    chk({tag, " we"},      32'(o_wb_we), 32'h0);
    chk({tag, " addr"},    o_wb_addr, 32'h0);
    chk({tag, " data"},    o_wb_data, 32'h0);
    chk({tag, " busy"},    32'(o_busy), 32'h0);
  endtask

  initial begin
    int hi;
    int lo;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0x00000001 to address 0
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0000);
    send_word(32'h0000_0001);
    wait_q(1, "t1 resp count");
    chk("t1 resp byte", 32'(popq()), 32'h06);
    chk("t1 cycles", n_cycles, 1);
    chk("t1 we", 32'(cap_we), 32'h1);
    chk("t1 addr", cap_addr, 32'h0000_0000);
    chk("t1 data", cap_data, 32'h0000_0001);
    chk("t1 late drop", late_drop, 0);
    chk("t1 early drop", early_drop, 0);
    wait_idle("t1 idle");

    // Read from 0x10, slave waits 3 cycles
    slave_delay = 3;
    slave_rdata = 32'h0000_000B;
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0010);
    wait_q(4, "t2 resp count");
    chk("t2 byte0", 32'(popq()), 32'h00);
    chk("t2 byte1", 32'(popq()), 32'h00);
    chk("t2 byte2", 32'(popq()), 32'h00);
    chk("t2 byte3", 32'(popq()), 32'h0B);
    chk("t2 cycles", n_cycles, 2);
    chk("t2 we", 32'(cap_we), 32'h0);
    chk("t2 addr", cap_addr, 32'h0000_0010);
    chk("t2 late drop", late_drop, 0);
    chk("t2 early drop", early_drop, 0);
    chk("t2 addr held", o_wb_addr, 32'h0000_0010);
    chk("t2 data held", o_wb_data, 32'h0000_0001);
    chk("t2 cyc low", 32'(o_wb_cyc), 32'h0);

    // Unknown command
    send_byte(8'h41, 1'b1);
    wait_q(1, "t3 resp count");
    chk("t3 resp byte", 32'(popq()), 32'h15);
    chk("t3 cycles", n_cycles, 2);
    wait_idle("t3 idle");

    // Broken frame inside a write, then a good read
    slave_delay = 1;
    slave_rdata = 32'h1234_5678;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b0);
    repeat (4 * CLKS) @(negedge clk);
    chk("t4 no resp", rxq.size(), 0);
    chk("t4 busy after ferr", 32'(o_busy), 32'h0);
    chk("t4 no cycle", n_cycles, 2);
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0020);
    wait_q(4, "t4 resp count");
    chk("t4 byte0", 32'(popq()), 32'h12);
    chk("t4 byte1", 32'(popq()), 32'h34);
    chk("t4 byte2", 32'(popq()), 32'h56);
    chk("t4 byte3", 32'(popq()), 32'h78);
    chk("t4 cycles", n_cycles, 3);
    chk("t4 addr", cap_addr, 32'h0000_0020);
    chk("t4 we", 32'(cap_we), 32'h0);
    wait_idle("t4 idle");

    // Slave never acks
    slave_en = 1'b0;
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0030);
    wait_cyc("t5 cyc rise");
`ifdef SILIFE_BRIDGE_TIMEOUT_EN
    hi = 0;
    while (o_wb_cyc && (hi < 1000)) begin
      hi++;
      @(negedge clk);
    end
    chk("t5 cyc high cycles", hi, 255);
    chk("t5 stb low", 32'(o_wb_stb), 32'h0);
    wait_q(1, "t5 resp count");
    chk("t5 resp byte", 32'(popq()), 32'h15);
    wait_idle("t5 idle");
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0060);
    wait_cyc("t6 cyc rise");
`else
    lo = 0;
    repeat (10000) begin
      @(negedge clk);
      if (!o_wb_cyc) lo++;
    end
    chk("t5 cyc low cycles", lo, 0);
    chk("t5 busy", 32'(o_busy), 32'h1);
    chk("t5 no resp", rxq.size(), 0);
`endif

    // Reset in the middle of a Wishbone cycle
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("t6 wb reset");
    @(negedge clk);
    reset = 1'b1;
    slave_en    = 1'b1;
    slave_delay = 0;
    slave_rdata = 32'hCAFE_F00D;
    repeat (4) @(negedge clk);

    // Reset in the middle of the response
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0040);
    hi = 0;
    while (uart_tx && (hi < 100 * CLKS)) begin
      @(negedge clk);
      hi++;
    end
    chk("t6 resp started", 32'(uart_tx), 32'h0);
    repeat (3 * CLKS) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("t6 resp reset");
    @(negedge clk);
    reset = 1'b1;
    lo = 0;
    repeat (30 * CLKS) begin
      @(negedge clk);
      if (!uart_tx) lo++;
    end
    chk("t6 tx quiet", lo, 0);
    rxq.delete();

    // Recovery command
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0050);
    send_word(32'hDEAD_BEEF);
    wait_q(1, "t6 resp count");
    chk("t6 resp byte", 32'(popq()), 32'h06);
    chk("t6 addr", cap_addr, 32'h0000_0050);
    chk("t6 data", cap_data, 32'hDEAD_BEEF);
    chk("t6 we", 32'(cap_we), 32'h1);
    chk("t6 addr held", o_wb_addr, 32'h0000_0050);
    wait_idle("t6 idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
